// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the IF/ID boundary: decodes RV32I/RV64I immediates
// and holds results in a 2-entry head/skid buffer with valid/ready on both sides.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // state | meaning
  // EMPTY | no buffered entry
  // ONE   | head register holds the only entry
  // FULL  | head holds the oldest entry, skid holds the next one

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t state;
  entry_t dec, head, skid;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       shamt6;
  logic       push, pop;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];

  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    shamt6  = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111: dec.fmt = FMT_I;
      7'b0010011: begin
        dec.fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHAMT : FMT_I;
        shamt6  = (XLEN == 64);
      end
      // word shifts on RV64 only take a 5-bit amount
      7'b0011011: if (XLEN == 64) dec.fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHAMT : FMT_I;
      7'b0100011: dec.fmt = FMT_S;
      7'b1100011: dec.fmt = FMT_B;
      7'b0110111, 7'b0010111: dec.fmt = FMT_U;
      7'b1101111: dec.fmt = FMT_J;
      default: dec.fmt = FMT_NONE;
    endcase

    case (dec.fmt)
      FMT_I: dec.imm = XLEN'($signed(in_instr[31:20]));
      FMT_S: dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      FMT_B: dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
      FMT_U: dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      FMT_J: dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
      FMT_SHAMT: begin
        if (shamt6) begin
          dec.imm = XLEN'(in_instr[25:20]);
        end else begin
          dec.imm     = XLEN'(in_instr[24:20]);
          dec.illegal = in_instr[25];
        end
      end
      default: dec.imm = '0;
    endcase
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          head  <= dec;
          state <= ONE;
        end
        ONE: begin
          if (push && !pop) begin
            skid  <= dec;
            state <= FULL;
          end else if (pop && !push) begin
            state <= EMPTY;
          end else if (push && pop) begin
            head <= dec;
          end
        end
        FULL: if (pop) begin
          head  <= skid;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;
  assign out_tag     = head.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against an arithmetic decode model and a queue-based buffer model.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_tag = '0;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
  } ent_t;

  ent_t q[$];
  bit   zero_ok = 1'b0;
  int   total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference decode from the field rules using plain integer arithmetic.
  function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint u, v;
    longint opc, f3;
    u = longint'({32'd0, ins});
    opc = u & 'h7F;
    f3  = (u >> 12) & 7;
    fmt = 0; ill = 0; v = 0;
    if (opc == 'h03 || opc == 'h67) fmt = 1;
    else if (opc == 'h13 || (opc == 'h1B && xlen == 64)) fmt = (f3 == 1 || f3 == 5) ? 6 : 1;
    else if (opc == 'h23) fmt = 2;
    else if (opc == 'h63) fmt = 3;
    else if (opc == 'h37 || opc == 'h17) fmt = 4;
    else if (opc == 'h6F) fmt = 5;
    case (fmt)
      1: begin v = u >> 20; if (v >= 2048) v -= 4096; end
      2: begin v = ((u >> 25) << 5) | ((u >> 7) & 31); if (v >= 2048) v -= 4096; end
      3: begin
        v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
            (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
        if (v >= 4096) v -= 8192;
      end
      4: begin v = u & 'hFFFFF000; if (v >= 64'h80000000) v -= 64'h100000000; end
      5: begin
        v = (((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
            (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      6: begin
        if (xlen == 64 && opc == 'h13) v = (u >> 20) & 63;
        else begin v = (u >> 20) & 31; ill = logic'((u >> 25) & 1); end
      end
      default: v = 0;
    endcase
    imm = (xlen == 32) ? (v & 64'hFFFFFFFF) : v;
  endfunction

  task automatic check_outs();
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    chk("in_ready32", in_ready32, q.size() != 2);
    chk("in_ready64", in_ready64, q.size() != 2);
    chk("out_valid32", out_valid32, q.size() != 0);
    chk("out_valid64", out_valid64, q.size() != 0);
    if (q.size() > 0) begin
      ref_dec(q[0].instr, 32, e_imm, e_fmt, e_ill);
      chk("imm32", imm32, e_imm);
      chk("fmt32", fmt32, e_fmt);
      chk("ill32", ill32, e_ill);
      chk("tag32", tag32, q[0].tag);
      ref_dec(q[0].instr, 64, e_imm, e_fmt, e_ill);
      chk("imm64", imm64, e_imm);
      chk("fmt64", fmt64, e_fmt);
      chk("ill64", ill64, e_ill);
      chk("tag64", tag64, q[0].tag);
    end else if (zero_ok) begin
      chk("rst_imm32", imm32, 0);
      chk("rst_fmt32", fmt32, 0);
      chk("rst_ill32", ill32, 0);
      chk("rst_tag32", tag32, 0);
      chk("rst_imm64", imm64, 0);
      chk("rst_tag64", tag64, 0);
    end
  endtask

  task automatic cycle();
    bit push, pop;
    check_outs();
    push = in_valid && (q.size() != 2);
    pop  = out_ready && (q.size() != 0);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      zero_ok = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{in_instr, in_tag});
        zero_ok = 1'b0;
      end
    end
    #1;
  endtask

  task automatic offer(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = $urandom;
    cycle();
  endtask

  logic [6:0] ops[11] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    zero_ok = 1'b1;
    rst_n = 1'b1;
    cycle();

    // addi x1,x0,-1, visible for exactly one cycle
    out_ready = 1'b1;
    offer(32'hFFF00093);
    in_valid = 1'b0;
    chk("t1_imm", imm32, 32'hFFFFFFFF);
    chk("t1_fmt", fmt32, 3'd1);
    cycle();
    chk("t1_gone", out_valid32, 1'b0);
    cycle();

    // beq -4, lui, jal +2048 back to back
    offer(32'hFE000EE3);
    chk("t2_b_imm", imm32, 32'hFFFFFFFC);
    chk("t2_b_fmt", fmt32, 3'd3);
    offer(32'h123452B7);
    chk("t2_u_imm", imm32, 32'h12345000);
    chk("t2_u_fmt", fmt32, 3'd4);
    offer(32'h0010006F);
    chk("t2_j_imm", imm32, 32'h00000800);
    chk("t2_j_fmt", fmt32, 3'd5);
    in_valid = 1'b0;
    cycle();

    // slli by 32: illegal on RV32, legal on RV64
    offer(32'h02009093);
    in_valid = 1'b0;
    chk("t3_ill32", ill32, 1'b1);
    chk("t3_fmt32", fmt32, 3'd6);
    chk("t3_imm32", imm32, 32'h0);
    chk("t3_ill64", ill64, 1'b0);
    chk("t3_imm64", imm64, 64'h20);
    cycle();

    // backpressure: third entry waits until the cycle after the first pop
    out_ready = 1'b0;
    offer(32'h00500113);
    offer(32'h00A00193);
    offer(32'hFFB00213);
    chk("t4_full", in_ready32, 1'b0);
    out_ready = 1'b1;
    cycle();
    chk("t4_ready_after_pop", in_ready32, 1'b1);
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // flush while full drops the offered entry too
    out_ready = 1'b0;
    offer(32'h00100093);
    offer(32'h00200093);
    flush = 1'b1;
    offer(32'h00300093);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_flush_valid", out_valid32, 1'b0);
    cycle();

    // reset while full, then a nop
    offer(32'h00100093);
    offer(32'h00200093);
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_rst_valid", out_valid32, 1'b0);
    chk("t6_rst_ready", in_ready32, 1'b1);
    out_ready = 1'b1;
    offer(32'h00000013);
    in_valid = 1'b0;
    chk("t6_nop_imm", imm32, 32'h0);
    chk("t6_nop_fmt", fmt32, 3'd1);
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins       = $urandom;
      ins[6:0]  = ops[$urandom_range(0, 10)];
      in_instr  = ins;
      in_tag    = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
